// File: rtl/cpu7_pkg.sv
// Shared types for the cpu7 multiply/divide arbitration logic.
// Also holds the index-width helper shared by the arbiter and its picker.
package cpu7_pkg;

    typedef enum logic [1:0] {
        MUL  = 2'd0,
        MULH = 2'd1,
        DIV  = 2'd2,
        MOD  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESPOND
    } muldiv_arb_state_t;

    // Index width that stays at least one bit wide for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpu7_rr_picker.sv
// Combinational round-robin picker: first set request bit after 'last', wrapping.
// Kept generic so other shared-resource arbiters can reuse it.
module cpu7_rr_picker
    import cpu7_pkg::*;
#(
    parameter int CORES = 4,
    parameter int IDX_W = idx_width(CORES)
) (
    input  logic [CORES-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Search starts one past the previous winner, so it has the lowest priority.
    always_comb begin
        valid    = 1'b0;
        index    = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 1; i <= CORES; i++) begin
            cand     = (int'(last) + i) % CORES;
            cand_idx = cand[IDX_W-1:0];
            if (!valid && req[cand_idx]) begin
                valid = 1'b1;
                index = cand_idx;
            end
        end
    end

endmodule

// File: rtl/cpu7_muldiv_arbiter.sv
// Round-robin arbiter sharing one multi-cycle mul/div unit among cpu7 cores,
// with a watchdog that completes a transaction with an error if the unit stalls.
module cpu7_muldiv_arbiter
    import cpu7_pkg::*;
#(
    parameter int CORES          = 4,
    parameter int DATA_WIDTH     = 56,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [CORES-1:0]            core_req,
    input  logic [2*CORES-1:0]          core_op,
    input  logic [DATA_WIDTH*CORES-1:0] core_a,
    input  logic [DATA_WIDTH*CORES-1:0] core_b,
    output logic [CORES-1:0]            core_done,
    output logic [DATA_WIDTH-1:0]       core_result,
    output logic                        core_err,
    output logic                        unit_start,
    output logic [1:0]                  unit_op,
    output logic [DATA_WIDTH-1:0]       unit_a,
    output logic [DATA_WIDTH-1:0]       unit_b,
    input  logic                        unit_done,
    input  logic [DATA_WIDTH-1:0]       unit_result,
    input  logic                        unit_err
);

    localparam int               IDX_W     = idx_width(CORES);
    localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(CORES - 1);

    muldiv_arb_state_t state, next_state;

    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] pick_index;
    logic             pick_valid;
    logic [CORES-1:0] mask;
    logic [CORES-1:0] eff_req;
    logic [CORES-1:0] grant_onehot;
    logic [CNT_W-1:0] timeout_cnt;
    logic             timed_out;

    assign eff_req      = core_req & ~mask;
    assign grant_onehot = CORES'(1) << grant;
    assign timed_out    = (timeout_cnt == CNT_LAST);

    cpu7_rr_picker #(
        .CORES (CORES),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (eff_req),
        .last  (last_grant),
        .valid (pick_valid),
        .index (pick_index)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pick_valid) next_state = ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (unit_done || timed_out) next_state = RESPOND;
            RESPOND: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered one state ahead, so each pulse lines up with its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_done   <= '0;
            core_result <= '0;
            core_err    <= 1'b0;
            unit_start  <= 1'b0;
            unit_op     <= '0;
            unit_a      <= '0;
            unit_b      <= '0;
            grant       <= '0;
            last_grant  <= LAST_INIT;
            mask        <= '0;
            timeout_cnt <= '0;
        end else begin
            unit_start <= 1'b0;
            core_done  <= '0;
            case (state)
                IDLE: begin
                    mask <= '0;
                    if (pick_valid) begin
                        grant      <= pick_index;
                        unit_op    <= core_op[2*pick_index +: 2];
                        unit_a     <= core_a[DATA_WIDTH*pick_index +: DATA_WIDTH];
                        unit_b     <= core_b[DATA_WIDTH*pick_index +: DATA_WIDTH];
                        unit_start <= 1'b1;
                    end
                end
                ISSUE: begin
                    timeout_cnt <= '0;
                end
                WAIT: begin
                    if (unit_done) begin
                        core_result <= unit_result;
                        core_err    <= unit_err;
                        core_done   <= grant_onehot;
                    end else if (timed_out) begin
                        core_result <= '0;
                        core_err    <= 1'b1;
                        core_done   <= grant_onehot;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                RESPOND: begin
                    last_grant <= grant;
                    mask       <= grant_onehot;
                end
                default: ;
            endcase
        end
    end

endmodule
